// File: rtl/xalu_ise_issue_if.sv
// -----------------------------------------------------------------------------
// xalu_ise_issue_if
//
// Bundles every handshake/bus signal of the custom-instruction issue unit:
//   request channel   : req_valid, req_ready, req_instr, req_rs1, req_rs2
//   writeback channel : rsp_valid, rsp_ready, rsp_rd, rsp_data, rsp_illegal
//   ISE ALU channel   : ise_fn, ise_imm, ise_in1, ise_in2, ise_val,
//                       ise_oval, ise_out
//
// Modports:
//   slave  - the issue unit itself (accepts requests, drives the ALU request,
//            produces the writeback response).
//   master - the surrounding environment (execute stage, writeback stage and
//            the ISE ALU), i.e. everything that talks to the issue unit.
// -----------------------------------------------------------------------------
interface xalu_ise_issue_if;

   // Request from the execute stage
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_instr;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;

   // Writeback response
   logic        rsp_valid;
   logic        rsp_ready;
   logic [4:0]  rsp_rd;
   logic [31:0] rsp_data;
   logic        rsp_illegal;

   // ISE ALU request / result
   logic [5:0]  ise_fn;
   logic [6:0]  ise_imm;
   logic [31:0] ise_in1;
   logic [31:0] ise_in2;
   logic        ise_val;
   logic        ise_oval;
   logic [31:0] ise_out;

   modport slave (
      input  req_valid, req_instr, req_rs1, req_rs2,
      input  rsp_ready,
      input  ise_oval, ise_out,
      output req_ready,
      output rsp_valid, rsp_rd, rsp_data, rsp_illegal,
      output ise_fn, ise_imm, ise_in1, ise_in2, ise_val
   );

   modport master (
      output req_valid, req_instr, req_rs1, req_rs2,
      output rsp_ready,
      output ise_oval, ise_out,
      input  req_ready,
      input  rsp_valid, rsp_rd, rsp_data, rsp_illegal,
      input  ise_fn, ise_imm, ise_in1, ise_in2, ise_val
   );

endinterface

// File: rtl/xalu_ise_issue.sv
// -----------------------------------------------------------------------------
// xalu_ise_issue
//
// Core-side issue unit for the custom-instruction (custom-0..3) ALU.
// An instruction is taken from the execute stage in IDLE, decoded into the
// ISE function/immediate fields and presented to the ISE ALU with a held
// valid.  The unit waits at most TIMEOUT cycles for the ALU's output-valid
// and then returns either the ALU result or an illegal-instruction
// indication on a valid/ready writeback channel.  Non-custom opcodes bypass
// the ALU and are answered as illegal on the next cycle.
//
// Parameters:
//   TIMEOUT   - maximum number of cycles ise_val stays high (1..255).
//
// Ports:
//   ise_clk   - sole clock, rising edge.
//   ise_rst   - synchronous active-high reset.
//   flush     - pipeline kill; drops whatever is in flight, no response.
//   bus       - xalu_ise_issue_if.slave; request, writeback and ISE ALU
//               channels (see the interface file for the signal list).
//
// Every output is driven straight from a register.  ise_fn / ise_imm /
// ise_in1 / ise_in2 are only non-zero while the ALU request is active.
// -----------------------------------------------------------------------------
module xalu_ise_issue #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic            ise_clk,
   input  logic            ise_rst,
   input  logic            flush,
   xalu_ise_issue_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Last count value before the wait is abandoned; the counter starts at 0
   // in the first BUSY cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   // -------------------------------------------------------------------------
   // Opcode decode helpers
   // -------------------------------------------------------------------------
   function automatic logic is_custom(input logic [6:0] opcode);
      case (opcode)
         7'h0B, 7'h2B, 7'h5B, 7'h7B: is_custom = 1'b1;
         default:                    is_custom = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] custom_index(input logic [6:0] opcode);
      case (opcode)
         7'h0B:   custom_index = 2'd0;
         7'h2B:   custom_index = 2'd1;
         7'h5B:   custom_index = 2'd2;
         7'h7B:   custom_index = 2'd3;
         default: custom_index = 2'd0;
      endcase
   endfunction

   // -------------------------------------------------------------------------
   // State and output registers, with their next-state values
   // -------------------------------------------------------------------------
   state_t      state_r,       state_s;
   logic [7:0]  cnt_r,         cnt_s;
   logic [4:0]  rd_r,          rd_s;
   logic        req_ready_r,   req_ready_s;
   logic        rsp_valid_r,   rsp_valid_s;
   logic [4:0]  rsp_rd_r,      rsp_rd_s;
   logic [31:0] rsp_data_r,    rsp_data_s;
   logic        rsp_illegal_r, rsp_illegal_s;
   logic        ise_val_r,     ise_val_s;
   logic [5:0]  ise_fn_r,      ise_fn_s;
   logic [6:0]  ise_imm_r,     ise_imm_s;
   logic [31:0] ise_in1_r,     ise_in1_s;
   logic [31:0] ise_in2_r,     ise_in2_s;

   // The rs1/rs2 register-number fields carry no meaning here; values
   // arrive already read on req_rs1/req_rs2.
   logic unused_instr_s;
   assign unused_instr_s = ^bus.req_instr[24:15];

   // Next-state and next-output decode for the IDLE/BUSY/RESP sequencer.
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      rd_s          = rd_r;
      req_ready_s   = req_ready_r;
      rsp_valid_s   = rsp_valid_r;
      rsp_rd_s      = rsp_rd_r;
      rsp_data_s    = rsp_data_r;
      rsp_illegal_s = rsp_illegal_r;
      ise_val_s     = ise_val_r;
      ise_fn_s      = ise_fn_r;
      ise_imm_s     = ise_imm_r;
      ise_in1_s     = ise_in1_r;
      ise_in2_s     = ise_in2_r;

      case (state_r)
         ST_IDLE: begin
            if (bus.req_valid) begin
               req_ready_s = 1'b0;
               if (is_custom(bus.req_instr[6:0])) begin
                  // Launch the ALU request; fields stay frozen in BUSY.
                  state_s   = ST_BUSY;
                  cnt_s     = 8'd0;
                  rd_s      = bus.req_instr[11:7];
                  ise_val_s = 1'b1;
                  ise_fn_s  = {1'b0, bus.req_instr[14:12],
                               custom_index(bus.req_instr[6:0])};
                  ise_imm_s = bus.req_instr[31:25];
                  ise_in1_s = bus.req_rs1;
                  ise_in2_s = bus.req_rs2;
               end else begin
                  // Not one of ours: answer illegal straight away.
                  state_s       = ST_RESP;
                  rsp_valid_s   = 1'b1;
                  rsp_rd_s      = bus.req_instr[11:7];
                  rsp_data_s    = 32'd0;
                  rsp_illegal_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_BUSY: begin
            if (bus.ise_oval) begin
               state_s       = ST_RESP;
               rsp_valid_s   = 1'b1;
               rsp_rd_s      = rd_r;
               // x0 is hard-wired zero, so never hand back a value for it.
               rsp_data_s    = (rd_r == 5'd0) ? 32'd0 : bus.ise_out;
               rsp_illegal_s = 1'b0;
               ise_val_s     = 1'b0;
               ise_fn_s      = 6'd0;
               ise_imm_s     = 7'd0;
               ise_in1_s     = 32'd0;
               ise_in2_s     = 32'd0;
            end else if (cnt_r == CNT_LAST) begin
               // ALU never recognised the op: report it as illegal.
               state_s       = ST_RESP;
               rsp_valid_s   = 1'b1;
               rsp_rd_s      = rd_r;
               rsp_data_s    = 32'd0;
               rsp_illegal_s = 1'b1;
               ise_val_s     = 1'b0;
               ise_fn_s      = 6'd0;
               ise_imm_s     = 7'd0;
               ise_in1_s     = 32'd0;
               ise_in2_s     = 32'd0;
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end

         ST_RESP: begin
            if (bus.rsp_ready) begin
               // Back to IDLE only; a new request is taken the cycle after.
               state_s       = ST_IDLE;
               req_ready_s   = 1'b1;
               rsp_valid_s   = 1'b0;
               rsp_rd_s      = 5'd0;
               rsp_data_s    = 32'd0;
               rsp_illegal_s = 1'b0;
            end else begin
               state_s = ST_RESP;
            end
         end

         default: begin
            // Unreachable encoding: recover to an empty IDLE.
            state_s       = ST_IDLE;
            cnt_s         = 8'd0;
            rd_s          = 5'd0;
            req_ready_s   = 1'b1;
            rsp_valid_s   = 1'b0;
            rsp_rd_s      = 5'd0;
            rsp_data_s    = 32'd0;
            rsp_illegal_s = 1'b0;
            ise_val_s     = 1'b0;
            ise_fn_s      = 6'd0;
            ise_imm_s     = 7'd0;
            ise_in1_s     = 32'd0;
            ise_in2_s     = 32'd0;
         end
      endcase
   end

   // State/output register bank; reset and flush both land in an empty IDLE.
   always_ff @(posedge ise_clk) begin
      if (ise_rst || flush) begin
         state_r       <= ST_IDLE;
         cnt_r         <= 8'd0;
         rd_r          <= 5'd0;
         req_ready_r   <= 1'b1;
         rsp_valid_r   <= 1'b0;
         rsp_rd_r      <= 5'd0;
         rsp_data_r    <= 32'd0;
         rsp_illegal_r <= 1'b0;
         ise_val_r     <= 1'b0;
         ise_fn_r      <= 6'd0;
         ise_imm_r     <= 7'd0;
         ise_in1_r     <= 32'd0;
         ise_in2_r     <= 32'd0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         rd_r          <= rd_s;
         req_ready_r   <= req_ready_s;
         rsp_valid_r   <= rsp_valid_s;
         rsp_rd_r      <= rsp_rd_s;
         rsp_data_r    <= rsp_data_s;
         rsp_illegal_r <= rsp_illegal_s;
         ise_val_r     <= ise_val_s;
         ise_fn_r      <= ise_fn_s;
         ise_imm_r     <= ise_imm_s;
         ise_in1_r     <= ise_in1_s;
         ise_in2_r     <= ise_in2_s;
      end
   end

   assign bus.req_ready   = req_ready_r;
   assign bus.rsp_valid   = rsp_valid_r;
   assign bus.rsp_rd      = rsp_rd_r;
   assign bus.rsp_data    = rsp_data_r;
   assign bus.rsp_illegal = rsp_illegal_r;
   assign bus.ise_val     = ise_val_r;
   assign bus.ise_fn      = ise_fn_r;
   assign bus.ise_imm     = ise_imm_r;
   assign bus.ise_in1     = ise_in1_r;
   assign bus.ise_in2     = ise_in2_r;

endmodule
